// File: rtl/usb_block_bridge.sv
// usb_block_bridge: joins the byte-wide USB protocol side to the wide-block
// application side. The RX path packs strobed bytes into BYTES-wide blocks.
// It has a selectable byte order and an optional partial-block timeout. The TX
// path serialises a captured block into a valid/ack byte stream. It can append
// an optional two's-complement checksum byte.
module usb_block_bridge #(
   parameter int BYTES       = 66,
   parameter int LSB_FIRST   = 1,
   parameter int TIMEOUT     = 0,
   parameter int TX_CHECKSUM = 0
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [7:0]           usb_data_in,
   input  logic                 new_byte,
   input  logic                 rx_abort,
   output logic [8*BYTES-1:0]   rx_block,
   output logic                 rx_valid,
   output logic                 rx_timeout,
   input  logic [8*BYTES-1:0]   tx_block,
   input  logic                 tx_load,
   output logic                 tx_busy,
   output logic                 tx_drop,
   output logic [7:0]           tx_byte,
   output logic                 tx_byte_valid,
   input  logic                 tx_byte_ack,
   output logic                 shift_out
);

   localparam int W  = 8 * BYTES;
   localparam int CW = $clog2(BYTES + 1);
   localparam int IW = $clog2(BYTES);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_CSUM, TX_DONE} tx_state_t;

   // Bit offset of byte k inside a block. RX and TX both use this mapping.
   function automatic int slot_pos(input int k);
      return (LSB_FIRST != 0) ? 8 * k : 8 * (BYTES - 1 - k);
   endfunction

   function automatic logic [7:0] pick_byte(input logic [W-1:0] blk, input int k);
      return blk[slot_pos(k) +: 8];
   endfunction

   logic [W-1:0]  rx_work;
   logic [W-1:0]  rx_work_next;
   logic [CW-1:0] rx_cnt;
   logic [TW-1:0] rx_timer;

   tx_state_t     tx_state;
   logic [W-1:0]  tx_shadow;
   logic [IW-1:0] tx_idx;
   logic [7:0]    tx_sum;
   logic [7:0]    tx_sum_next;

   // The working register with the incoming byte merged in. On completion this
   // value is copied straight to rx_block, so the final byte is included.
   always_comb begin
      rx_work_next = rx_work;
      rx_work_next[slot_pos(int'(rx_cnt)) +: 8] = usb_data_in;
   end

   // RX assembly, completion, abort and idle timeout. An abort beats a
   // simultaneous byte, and an arriving byte beats an expiring timeout.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         rx_cnt     <= '0;
         rx_timer   <= '0;
         rx_block   <= '0;
         rx_valid   <= 1'b0;
         rx_timeout <= 1'b0;
      end else begin
         rx_valid   <= 1'b0;
         rx_timeout <= 1'b0;
         if (rx_abort) begin
            rx_cnt   <= '0;
            rx_timer <= '0;
         end else if (new_byte) begin
            rx_work  <= rx_work_next;
            rx_timer <= '0;
            if (rx_cnt == CW'(BYTES - 1)) begin
               rx_block <= rx_work_next;
               rx_valid <= 1'b1;
               rx_cnt   <= '0;
            end else begin
               rx_cnt <= rx_cnt + 1'b1;
            end
         end else if (TIMEOUT > 0 && rx_cnt != '0) begin
            if (rx_timer == TW'(TIMEOUT - 1)) begin
               rx_cnt     <= '0;
               rx_timer   <= '0;
               rx_timeout <= 1'b1;
            end else begin
               rx_timer <= rx_timer + 1'b1;
            end
         end else begin
            rx_timer <= '0;
         end
      end
   end

   assign tx_sum_next = tx_sum + tx_byte;

   // TX state machine. tx_byte is preloaded one state ahead, so the output
   // is already registered and stays stable until it is acked.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         tx_state      <= TX_IDLE;
         tx_shadow     <= '0;
         tx_idx        <= '0;
         tx_sum        <= '0;
         tx_byte       <= '0;
         tx_byte_valid <= 1'b0;
         tx_busy       <= 1'b0;
         tx_drop       <= 1'b0;
         shift_out     <= 1'b0;
      end else begin
         tx_drop <= tx_load && (tx_state != TX_IDLE);
         case (tx_state)
            TX_IDLE: begin
               shift_out <= 1'b0;
               if (tx_load) begin
                  tx_shadow     <= tx_block;
                  tx_idx        <= '0;
                  tx_sum        <= '0;
                  tx_byte       <= pick_byte(tx_block, 0);
                  tx_byte_valid <= 1'b1;
                  tx_busy       <= 1'b1;
                  tx_state      <= TX_SEND;
               end
            end
            TX_SEND: begin
               if (tx_byte_ack) begin
                  tx_sum <= tx_sum_next;
                  if (tx_idx == IW'(BYTES - 1)) begin
                     if (TX_CHECKSUM != 0) begin
                        tx_byte  <= 8'd0 - tx_sum_next;
                        tx_state <= TX_CSUM;
                     end else begin
                        tx_byte       <= '0;
                        tx_byte_valid <= 1'b0;
                        shift_out     <= 1'b1;
                        tx_state      <= TX_DONE;
                     end
                  end else begin
                     tx_idx  <= tx_idx + 1'b1;
                     tx_byte <= pick_byte(tx_shadow, int'(tx_idx) + 1);
                  end
               end
            end
            TX_CSUM: begin
               if (tx_byte_ack) begin
                  tx_byte       <= '0;
                  tx_byte_valid <= 1'b0;
                  shift_out     <= 1'b1;
                  tx_state      <= TX_DONE;
               end
            end
            TX_DONE: begin
               shift_out <= 1'b0;
               tx_busy   <= 1'b0;
               tx_state  <= TX_IDLE;
            end
            default: begin
               tx_state <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_block_bridge.sv
// tb_usb_block_bridge: directed bench for usb_block_bridge. Instance A uses
// LSB_FIRST=1, TIMEOUT=5 and a checksum. Instance B uses LSB_FIRST=0, no
// timeout and no checksum. Both instances share every input.
module tb_usb_block_bridge;

   logic        clk;
   logic        n_rst;
   logic [7:0]  usb_data_in;
   logic        new_byte;
   logic        rx_abort;
   logic [31:0] tx_block;
   logic        tx_load;
   logic        tx_byte_ack;

   logic [31:0] rxBlockA, rxBlockB;
   logic        rxValidA, rxValidB, rxTimeoutA, rxTimeoutB;
   logic        txBusyA, txBusyB, txDropA, txDropB;
   logic [7:0]  txByteA, txByteB;
   logic        txValidA, txValidB, shiftA, shiftB;

   int compared;
   int mismatched;
   logic [7:0] expStream [5];

   usb_block_bridge #(.BYTES(4), .LSB_FIRST(1), .TIMEOUT(5), .TX_CHECKSUM(1)) dutA (
      .clk(clk), .n_rst(n_rst), .usb_data_in(usb_data_in), .new_byte(new_byte),
      .rx_abort(rx_abort), .rx_block(rxBlockA), .rx_valid(rxValidA),
      .rx_timeout(rxTimeoutA), .tx_block(tx_block), .tx_load(tx_load),
      .tx_busy(txBusyA), .tx_drop(txDropA), .tx_byte(txByteA),
      .tx_byte_valid(txValidA), .tx_byte_ack(tx_byte_ack), .shift_out(shiftA)
   );

   usb_block_bridge #(.BYTES(4), .LSB_FIRST(0), .TIMEOUT(0), .TX_CHECKSUM(0)) dutB (
      .clk(clk), .n_rst(n_rst), .usb_data_in(usb_data_in), .new_byte(new_byte),
      .rx_abort(rx_abort), .rx_block(rxBlockB), .rx_valid(rxValidB),
      .rx_timeout(rxTimeoutB), .tx_block(tx_block), .tx_load(tx_load),
      .tx_busy(txBusyB), .tx_drop(txDropB), .tx_byte(txByteB),
      .tx_byte_valid(txValidB), .tx_byte_ack(tx_byte_ack), .shift_out(shiftB)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge so that outputs are settled.
   task tick();
      @(posedge clk);
      #1;
   endtask

   // Present one RX cycle (byte strobe and/or abort), then release the strobes.
   task applyStimulus(input logic [7:0] d, input logic nb, input logic ab);
      usb_data_in = d;
      new_byte    = nb;
      rx_abort    = ab;
      tick();
      new_byte    = 1'b0;
      rx_abort    = 1'b0;
   endtask

   task checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      n_rst       = 1'b0;
      usb_data_in = 8'h00;
      new_byte    = 1'b0;
      rx_abort    = 1'b0;
      tx_block    = 32'h0;
      tx_load     = 1'b0;
      tx_byte_ack = 1'b0;
      expStream[0] = 8'h01;
      expStream[1] = 8'h02;
      expStream[2] = 8'h03;
      expStream[3] = 8'h04;
      expStream[4] = 8'hF6;

      tick();
      tick();
      checkOutput("reset rx_block", rxBlockA, 0);
      checkOutput("reset rx_valid", rxValidA, 0);
      checkOutput("reset tx_busy", txBusyA, 0);
      checkOutput("reset tx_byte_valid", txValidA, 0);
      checkOutput("reset tx_byte", txByteA, 0);
      checkOutput("reset shift_out", shiftA, 0);
      n_rst = 1'b1;
      tick();

      $display("[TB] back-to-back block, both byte orders");
      applyStimulus(8'h11, 1, 0);
      applyStimulus(8'h22, 1, 0);
      applyStimulus(8'h33, 1, 0);
      checkOutput("rx_valid early", rxValidA, 0);
      applyStimulus(8'h44, 1, 0);
      checkOutput("lsb block", rxBlockA, 32'h44332211);
      checkOutput("lsb rx_valid", rxValidA, 1);
      checkOutput("msb block", rxBlockB, 32'h11223344);
      tick();
      checkOutput("rx_valid single pulse", rxValidA, 0);

      $display("[TB] spaced bytes");
      applyStimulus(8'hA1, 1, 0); tick(); tick();
      applyStimulus(8'hB2, 1, 0); tick(); tick();
      applyStimulus(8'hC3, 1, 0); tick(); tick();
      applyStimulus(8'hD4, 1, 0);
      checkOutput("spaced msb block", rxBlockB, 32'hA1B2C3D4);
      checkOutput("spaced msb valid", rxValidB, 1);
      checkOutput("spaced lsb block", rxBlockA, 32'hD4C3B2A1);

      $display("[TB] eight bytes back-to-back");
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(8'(i), 1, 0);
         if (i == 4) begin
            checkOutput("b2b first valid", rxValidB, 1);
            checkOutput("b2b first block", rxBlockB, 32'h01020304);
         end
         if (i == 5) checkOutput("b2b gap valid", rxValidB, 0);
      end
      checkOutput("b2b second valid", rxValidB, 1);
      checkOutput("b2b second block", rxBlockB, 32'h05060708);
      checkOutput("b2b lsb block", rxBlockA, 32'h08070605);

      $display("[TB] partial block timeout");
      applyStimulus(8'h55, 1, 0);
      applyStimulus(8'h66, 1, 0);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("timeout not yet", rxTimeoutA, 0);
      tick();
      checkOutput("timeout pulse", rxTimeoutA, 1);
      checkOutput("timeout block kept", rxBlockA, 32'h08070605);
      checkOutput("timeout valid quiet", rxValidA, 0);
      tick();
      checkOutput("timeout single pulse", rxTimeoutA, 0);
      applyStimulus(8'h00, 0, 1);
      applyStimulus(8'h9A, 1, 0);
      applyStimulus(8'hBC, 1, 0);
      applyStimulus(8'hDE, 1, 0);
      applyStimulus(8'hF0, 1, 0);
      checkOutput("post timeout block", rxBlockA, 32'hF0DEBC9A);
      checkOutput("post timeout valid", rxValidA, 1);

      $display("[TB] abort with byte");
      applyStimulus(8'h01, 1, 0);
      applyStimulus(8'h02, 1, 0);
      applyStimulus(8'hFF, 1, 1);
      applyStimulus(8'h03, 1, 0);
      applyStimulus(8'h04, 1, 0);
      applyStimulus(8'h05, 1, 0);
      checkOutput("abort no early valid", rxValidA, 0);
      applyStimulus(8'h06, 1, 0);
      checkOutput("abort lsb block", rxBlockA, 32'h06050403);
      checkOutput("abort msb block", rxBlockB, 32'h03040506);

      $display("[TB] transmit with checksum, ack every other cycle");
      tx_block = 32'h04030201;
      tx_load  = 1'b1;
      tick();
      tx_load  = 1'b0;
      checkOutput("tx valid after load", txValidA, 1);
      checkOutput("tx busy after load", txBusyA, 1);
      checkOutput("msb tx first byte", txByteB, 8'h04);
      for (int i = 0; i < 5; i++) begin
         checkOutput("tx stream byte", txByteA, expStream[i]);
         checkOutput("tx stream valid", txValidA, 1);
         tx_byte_ack = 1'b0;
         if (i == 1) begin
            tx_block = 32'hFFFFFFFF;
            tx_load  = 1'b1;
         end
         tick();
         if (i == 1) begin
            tx_load  = 1'b0;
            tx_block = 32'h04030201;
            checkOutput("tx_drop pulse", txDropA, 1);
         end
         checkOutput("tx byte stable", txByteA, expStream[i]);
         tx_byte_ack = 1'b1;
         tick();
         tx_byte_ack = 1'b0;
         if (i == 3) checkOutput("msb shift_out", shiftB, 1);
         if (i == 2) checkOutput("tx_drop single", txDropA, 0);
      end
      checkOutput("shift_out after csum", shiftA, 1);
      checkOutput("tx valid low at done", txValidA, 0);
      tick();
      checkOutput("shift_out single", shiftA, 0);
      checkOutput("tx idle", txBusyA, 0);

      $display("[TB] transmit with ack held high");
      tx_byte_ack = 1'b1;
      tx_load     = 1'b1;
      tick();
      tx_load     = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checkOutput("held shift early", shiftA, 0);
      tick();
      checkOutput("held msb shift", shiftB, 1);
      checkOutput("held lsb shift early", shiftA, 0);
      tick();
      checkOutput("held lsb shift", shiftA, 1);
      tick();
      tx_load = 1'b1;
      tick();
      tx_load = 1'b0;
      checkOutput("reload accepted", txBusyA, 1);
      checkOutput("reload no drop", txDropA, 0);

      $display("[TB] reset mid-block");
      applyStimulus(8'h77, 1, 0);
      n_rst = 1'b0;
      tick();
      checkOutput("mid reset rx_block", rxBlockA, 0);
      checkOutput("mid reset tx_busy", txBusyA, 0);
      checkOutput("mid reset tx_byte_valid", txValidA, 0);
      checkOutput("mid reset tx_byte", txByteA, 0);
      checkOutput("mid reset shift_out", shiftA, 0);
      checkOutput("mid reset rx_valid", rxValidA, 0);
      n_rst       = 1'b1;
      tx_byte_ack = 1'b0;
      tick();
      checkOutput("post reset shift_out", shiftA, 0);
      checkOutput("post reset rx_valid", rxValidA, 0);
      applyStimulus(8'h21, 1, 0);
      applyStimulus(8'h43, 1, 0);
      applyStimulus(8'h65, 1, 0);
      applyStimulus(8'h87, 1, 0);
      checkOutput("post reset block", rxBlockA, 32'h87654321);
      checkOutput("post reset valid", rxValidA, 1);
      tx_block = 32'h0A0B0C0D;
      tx_load  = 1'b1;
      tick();
      tx_load  = 1'b0;
      checkOutput("post reset tx byte", txByteA, 8'h0D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
